// File: rtl/irq_nested_ctrl_if.sv
// Bus between the nested interrupt controller and its environment:
// raw lines, per-line configuration, the core req/ack/eoi handshake and status.
interface irq_nested_ctrl_if #(
    parameter int N = 8
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   irq;
    logic [N-1:0]   edge_sel;
    logic [N-1:0]   mask;
    logic           irq_req;
    logic [IDW-1:0] irq_vec;
    logic           irq_ack;
    logic           eoi;
    logic [N-1:0]   pending;
    logic [N-1:0]   in_service;

    // Environment side: peripherals plus CPU core
    modport master (
        output irq, edge_sel, mask, irq_ack, eoi,
        input  irq_req, irq_vec, pending, in_service
    );

    // Controller side
    modport slave (
        input  irq, edge_sel, mask, irq_ack, eoi,
        output irq_req, irq_vec, pending, in_service
    );
endinterface

// File: rtl/irq_nested_ctrl.sv
// Vectored interrupt controller with edge/level latching, masking, fixed
// priority (highest index wins) and in-service tracking for nesting.
module irq_nested_ctrl #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    irq_nested_ctrl_if.slave bus
);
    localparam int IDW = $clog2(N);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]     state;
    logic [N-1:0]   irq_q;
    logic [N-1:0]   pending_r;
    logic [N-1:0]   in_service_r;
    logic           irq_req_r;
    logic [IDW-1:0] irq_vec_r;

    logic [N-1:0]   above;
    logic [N-1:0]   eligible;
    logic [N-1:0]   eoi_clr;
    logic [N-1:0]   ack_set;
    logic [IDW-1:0] best;
    logic           any_elig;
    logic           vec_elig;
    logic           ack_ok;
    logic           seen;

    assign bus.irq_req    = irq_req_r;
    assign bus.irq_vec    = irq_vec_r;
    assign bus.pending    = pending_r;
    assign bus.in_service = in_service_r;

    // Priority ceiling, eligibility, best candidate, eoi target and ack target
    always_comb begin
        seen    = 1'b0;
        above   = '0;
        eoi_clr = '0;
        ack_set = '0;
        best    = '0;
        // above[i] is set when no in-service bit sits at index i or higher
        for (int unsigned j = 0; j < N; j++) begin
            seen          = seen | in_service_r[N-1-j];
            above[N-1-j]  = ~seen;
        end
        eligible = pending_r & ~bus.mask & ~in_service_r & above;
        ack_ok   = (state == REQ) && bus.irq_ack;
        for (int unsigned i = 0; i < N; i++) begin
            if (eligible[i]) begin
                best = IDW'(i);
            end
            if (in_service_r[i]) begin
                eoi_clr    = '0;
                eoi_clr[i] = bus.eoi;
            end
            ack_set[i] = ack_ok && (irq_vec_r == IDW'(i));
        end
        any_elig = |eligible;
        vec_elig = eligible[irq_vec_r];
    end

    // Line sampling, pending latch and in-service bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q        <= '0;
            pending_r    <= '0;
            in_service_r <= '0;
        end else begin
            irq_q        <= bus.irq;
            pending_r    <= (bus.edge_sel & ((bus.irq & ~irq_q) | (pending_r & ~ack_set)))
                          | (~bus.edge_sel & bus.irq);
            in_service_r <= (in_service_r & ~eoi_clr) | ack_set;
        end
    end

    // Request handshake FSM: latch the best vector, hold it until ack or withdraw
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            irq_req_r <= 1'b0;
            irq_vec_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state     <= REQ;
                        irq_req_r <= 1'b1;
                        irq_vec_r <= best;
                    end
                end
                REQ: begin
                    if (ack_ok || !vec_elig) begin
                        state     <= IDLE;
                        irq_req_r <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    irq_req_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
